// File: rtl/dbg_hex_viewer.sv
// rtl/dbg_hex_viewer.sv - debug word viewer: channel select, paging, freeze snapshot, auto-rotate to hex digits
module dbg_hex_viewer #(
    parameter int NCH     = 9,
    parameter int DW      = 32,
    parameter int NDIG    = 6,
    parameter int ROT_DIV = 50000000,
    localparam int CW     = $clog2(NCH),
    localparam int NPAGE  = (DW + 4 * NDIG - 1) / (4 * NDIG),
    localparam int PW     = (NPAGE > 1) ? $clog2(NPAGE) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH*DW-1:0]   ch_data,
    input  logic                btn_next,
    input  logic                btn_prev,
    input  logic                btn_page,
    input  logic                btn_freeze,
    input  logic                btn_auto,
    output logic [NDIG*4-1:0]   digits,
    output logic [NDIG-1:0]     blank,
    output logic [CW-1:0]       ch_idx,
    output logic [PW-1:0]       page,
    output logic                frozen,
    output logic                auto
);

    localparam int RW = $clog2(ROT_DIV);

    logic [RW-1:0]     rot_cnt;
    logic [DW-1:0]     hold;
    logic [DW-1:0]     live_word;
    logic [DW-1:0]     shown;
    logic              manual;
    logic              wrap;
    logic              rot_step;
    logic [CW-1:0]     ch_nxt;
    logic [PW-1:0]     page_nxt;
    logic [RW-1:0]     cnt_nxt;
    logic [NDIG*4-1:0] digits_d;
    logic [NDIG-1:0]   blank_d;

    always_comb begin
        live_word = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch_idx == CW'(k)) live_word = ch_data[k*DW +: DW];
        end
    end

    assign shown = frozen ? hold : live_word;

    // Manual stepping is gated by the current freeze state, so a freeze toggle
    // arriving with NEXT/PREV still lets the channel move.
    assign manual   = !frozen && (btn_next ^ btn_prev);
    assign wrap     = (rot_cnt == RW'(ROT_DIV - 1));
    assign rot_step = auto && !frozen && !btn_auto && !manual && wrap;

    always_comb begin
        ch_nxt = ch_idx;
        if (manual && btn_prev)
            ch_nxt = (ch_idx == '0) ? CW'(NCH - 1) : ch_idx - CW'(1);
        else if (manual || rot_step)
            ch_nxt = (ch_idx == CW'(NCH - 1)) ? '0 : ch_idx + CW'(1);

        page_nxt = page;
        if (manual || rot_step)
            page_nxt = '0;
        else if (btn_page)
            page_nxt = (page == PW'(NPAGE - 1)) ? '0 : page + PW'(1);

        cnt_nxt = rot_cnt;
        if (btn_auto)
            cnt_nxt = '0;
        else if (auto && !frozen)
            cnt_nxt = (manual || wrap) ? '0 : rot_cnt + RW'(1);
    end

    // Nibbles past the word width are blanked; DW is a multiple of 4 so a
    // nibble is either fully inside the word or fully outside it.
    always_comb begin
        int base;
        digits_d = '0;
        blank_d  = '0;
        base     = 0;
        for (int i = 0; i < NDIG; i++) begin
            base = int'(page) * NDIG + i;
            if (base * 4 >= DW)
                blank_d[i] = 1'b1;
            else
                digits_d[i*4 +: 4] = shown[base*4 +: 4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_idx  <= '0;
            page    <= '0;
            frozen  <= 1'b0;
            auto    <= 1'b0;
            rot_cnt <= '0;
            hold    <= '0;
            digits  <= '0;
            blank   <= '0;
        end else begin
            if (btn_freeze) begin
                frozen <= ~frozen;
                if (!frozen) hold <= live_word;
            end
            if (btn_auto) auto <= ~auto;
            ch_idx  <= ch_nxt;
            page    <= page_nxt;
            rot_cnt <= cnt_nxt;
            digits  <= digits_d;
            blank   <= blank_d;
        end
    end

endmodule

// File: tb/tb_dbg_hex_viewer.sv
// tb/tb_dbg_hex_viewer.sv - directed self-checking bench for dbg_hex_viewer
module tb_dbg_hex_viewer;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [287:0]  ch_data;
    logic          btn_next = 1'b0;
    logic          btn_prev = 1'b0;
    logic          btn_page = 1'b0;
    logic          btn_freeze = 1'b0;
    logic          btn_auto = 1'b0;
    logic [23:0]   digits;
    logic [5:0]    blank;
    logic [3:0]    ch_idx;
    logic [0:0]    page;
    logic          frozen;
    logic          auto;

    logic [31:0]   ch_word [9];
    int            vectors = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 9; k++) ch_data[k*32 +: 32] = ch_word[k];
    end

    dbg_hex_viewer #(.NCH(9), .DW(32), .NDIG(6), .ROT_DIV(4)) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data),
        .btn_next(btn_next), .btn_prev(btn_prev), .btn_page(btn_page),
        .btn_freeze(btn_freeze), .btn_auto(btn_auto),
        .digits(digits), .blank(blank), .ch_idx(ch_idx), .page(page),
        .frozen(frozen), .auto(auto)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic nx, input logic pv, input logic pg, input logic fz, input logic au);
        btn_next = nx; btn_prev = pv; btn_page = pg; btn_freeze = fz; btn_auto = au;
        @(negedge clk);
        btn_next = 0; btn_prev = 0; btn_page = 0; btn_freeze = 0; btn_auto = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        vectors++; if (digits !== 24'h0) begin miscompares++; $display("FAIL reset_digits got %h want %h", digits, 24'h0); end
        vectors++; if (blank !== 6'b0) begin miscompares++; $display("FAIL reset_blank got %b want %b", blank, 6'b0); end
        vectors++; if ({ch_idx, page, frozen, auto} !== 7'b0) begin miscompares++;
            $display("FAIL reset_state got ch=%0d pg=%0d fz=%b au=%b want all 0", ch_idx, page, frozen, auto); end
        rst = 1'b0;
        tick(2);
        vectors++; if (digits !== 24'h345678) begin miscompares++; $display("FAIL ch0_digits got %h want %h", digits, 24'h345678); end
        vectors++; if (blank !== 6'b000000) begin miscompares++; $display("FAIL ch0_blank got %b want %b", blank, 6'b000000); end
        vectors++; if (ch_idx !== 4'd0 || page !== 1'b0) begin miscompares++;
            $display("FAIL ch0_sel got ch=%0d pg=%0d want ch=0 pg=0", ch_idx, page); end
    endtask

    task automatic test_page();
        press(0, 0, 1, 0, 0);
        tick(1);
        vectors++; if (page !== 1'b1) begin miscompares++; $display("FAIL page1 got %0d want 1", page); end
        vectors++; if (digits !== 24'h000012) begin miscompares++; $display("FAIL page1_digits got %h want %h", digits, 24'h000012); end
        vectors++; if (blank !== 6'b111100) begin miscompares++; $display("FAIL page1_blank got %b want %b", blank, 6'b111100); end
        press(0, 0, 1, 0, 0);
        tick(1);
        vectors++; if (page !== 1'b0) begin miscompares++; $display("FAIL page_wrap got %0d want 0", page); end
        vectors++; if (digits !== 24'h345678) begin miscompares++; $display("FAIL page_wrap_digits got %h want %h", digits, 24'h345678); end
    endtask

    task automatic test_channel();
        press(0, 1, 0, 0, 0);
        vectors++; if (ch_idx !== 4'd8) begin miscompares++; $display("FAIL prev_wrap got %0d want 8", ch_idx); end
        tick(1);
        vectors++; if (digits !== 24'h080808) begin miscompares++; $display("FAIL ch8_digits got %h want %h", digits, 24'h080808); end
        press(1, 0, 0, 0, 0);
        vectors++; if (ch_idx !== 4'd0) begin miscompares++; $display("FAIL next_wrap got %0d want 0", ch_idx); end
        press(1, 1, 0, 0, 0);
        vectors++; if (ch_idx !== 4'd0) begin miscompares++; $display("FAIL next_prev_same got %0d want 0", ch_idx); end
        press(0, 0, 1, 0, 0);
        press(1, 0, 0, 0, 0);
        vectors++; if (ch_idx !== 4'd1 || page !== 1'b0) begin miscompares++;
            $display("FAIL next_clears_page got ch=%0d pg=%0d want ch=1 pg=0", ch_idx, page); end
        press(1, 0, 1, 0, 0);
        vectors++; if (ch_idx !== 4'd2 || page !== 1'b0) begin miscompares++;
            $display("FAIL next_overrides_page got ch=%0d pg=%0d want ch=2 pg=0", ch_idx, page); end
    endtask

    task automatic test_freeze();
        press(1, 0, 0, 0, 0);
        tick(1);
        vectors++; if (digits !== 24'hAABBBB) begin miscompares++; $display("FAIL ch3_live got %h want %h", digits, 24'hAABBBB); end
        press(0, 0, 0, 1, 0);
        vectors++; if (frozen !== 1'b1) begin miscompares++; $display("FAIL freeze_on got %b want 1", frozen); end
        ch_word[3] = 32'h0;
        tick(2);
        vectors++; if (digits !== 24'hAABBBB) begin miscompares++; $display("FAIL freeze_hold got %h want %h", digits, 24'hAABBBB); end
        press(1, 0, 0, 0, 0);
        vectors++; if (ch_idx !== 4'd3) begin miscompares++; $display("FAIL next_frozen got %0d want 3", ch_idx); end
        press(0, 0, 1, 0, 0);
        tick(1);
        vectors++; if (digits !== 24'h0000AA || blank !== 6'b111100) begin miscompares++;
            $display("FAIL frozen_page got %h/%b want %h/%b", digits, blank, 24'h0000AA, 6'b111100); end
        press(0, 0, 1, 0, 0);
        press(0, 0, 0, 1, 0);
        vectors++; if (digits !== 24'hAABBBB) begin miscompares++; $display("FAIL unfreeze_lat1 got %h want %h", digits, 24'hAABBBB); end
        tick(1);
        vectors++; if (digits !== 24'h000000) begin miscompares++; $display("FAIL unfreeze_live got %h want %h", digits, 24'h0); end
        ch_word[3] = 32'hAAAABBBB;
        press(0, 0, 0, 1, 1'b1 ^ 1'b1);
        ch_word[3] = 32'h0;
        press(0, 0, 0, 1, 0);
        tick(1);
        vectors++; if (digits !== 24'h000000) begin miscompares++; $display("FAIL refreeze_live got %h want %h", digits, 24'h0); end
        ch_word[3] = 32'hAAAABBBB;
        tick(1);
        press(1, 0, 0, 1, 0);
        vectors++; if (ch_idx !== 4'd4 || frozen !== 1'b1) begin miscompares++;
            $display("FAIL freeze_next got ch=%0d fz=%b want ch=4 fz=1", ch_idx, frozen); end
        tick(1);
        vectors++; if (digits !== 24'hAABBBB) begin miscompares++; $display("FAIL freeze_next_old got %h want %h", digits, 24'hAABBBB); end
        press(0, 0, 0, 1, 0);
        tick(1);
        vectors++; if (digits !== 24'h040404) begin miscompares++; $display("FAIL freeze_next_new got %h want %h", digits, 24'h040404); end
    endtask

    task automatic test_auto();
        do_reset();
        press(0, 0, 0, 0, 1);
        vectors++; if (auto !== 1'b1) begin miscompares++; $display("FAIL auto_on got %b want 1", auto); end
        tick(3);
        vectors++; if (ch_idx !== 4'd0) begin miscompares++; $display("FAIL auto_pre got %0d want 0", ch_idx); end
        tick(1);
        vectors++; if (ch_idx !== 4'd1) begin miscompares++; $display("FAIL auto_step1 got %0d want 1", ch_idx); end
        tick(4);
        vectors++; if (ch_idx !== 4'd2) begin miscompares++; $display("FAIL auto_step2 got %0d want 2", ch_idx); end
        tick(2);
        press(0, 0, 0, 1, 0);
        tick(6);
        vectors++; if (ch_idx !== 4'd2) begin miscompares++; $display("FAIL auto_frozen got %0d want 2", ch_idx); end
        press(0, 0, 0, 1, 0);
        vectors++; if (ch_idx !== 4'd2) begin miscompares++; $display("FAIL auto_unfreeze got %0d want 2", ch_idx); end
        tick(1);
        vectors++; if (ch_idx !== 4'd3) begin miscompares++; $display("FAIL auto_resume got %0d want 3", ch_idx); end
        tick(2);
        press(1, 0, 0, 0, 0);
        vectors++; if (ch_idx !== 4'd4) begin miscompares++; $display("FAIL auto_manual got %0d want 4", ch_idx); end
        tick(3);
        vectors++; if (ch_idx !== 4'd4) begin miscompares++; $display("FAIL auto_cnt_cleared got %0d want 4", ch_idx); end
        tick(1);
        vectors++; if (ch_idx !== 4'd5) begin miscompares++; $display("FAIL auto_after_manual got %0d want 5", ch_idx); end
    endtask

    task automatic test_async_reset();
        press(0, 0, 0, 1, 0);
        tick(1);
        vectors++; if (digits !== 24'h050505 || frozen !== 1'b1) begin miscompares++;
            $display("FAIL pre_rst got %h fz=%b want %h fz=1", digits, frozen, 24'h050505); end
        #2 rst = 1'b1;
        #1;
        vectors++; if ({ch_idx, page, frozen, auto} !== 7'b0 || digits !== 24'h0 || blank !== 6'b0) begin miscompares++;
            $display("FAIL async_rst got ch=%0d pg=%0d fz=%b au=%b dg=%h bl=%b want all 0", ch_idx, page, frozen, auto, digits, blank); end
        @(negedge clk);
        rst = 1'b0;
        press(0, 0, 0, 0, 1);
        tick(3);
        vectors++; if (ch_idx !== 4'd0) begin miscompares++; $display("FAIL restart_pre got %0d want 0", ch_idx); end
        tick(1);
        vectors++; if (ch_idx !== 4'd1) begin miscompares++; $display("FAIL restart_step got %0d want 1", ch_idx); end
    endtask

    initial begin
        for (int k = 0; k < 9; k++) ch_word[k] = 32'h01010101 * k;
        ch_word[0] = 32'h12345678;
        ch_word[3] = 32'hAAAABBBB;
        @(negedge clk);
        test_reset();
        test_page();
        test_channel();
        test_freeze();
        test_auto();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
